// File: rtl/reg_wb_sched.sv
// reg_wb_sched: round-robin write-back port arbiter with a destination-register busy scoreboard
module reg_wb_sched #(
    parameter int NREQ = 3,
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_sel,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        busC,
    output logic [AW-1:0]        busCsel,
    output logic                 en,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_sel,
    input  logic [AW-1:0]        chk_selA,
    input  logic [AW-1:0]        chk_selB,
    output logic                 hazard,
    output logic [2**AW-1:0]     busy_mask,
    output logic [1:0]           grant_ptr
);
    logic [1:0]        g_idx;
    logic [1:0]        nxt_ptr;
    logic [AW-1:0]     a_sel;
    logic [DW-1:0]     a_data;
    logic [2**AW-1:0]  busy_nxt;
    logic              acc;
    logic              wb;

    function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] v, input logic [1:0] p);
        logic [NREQ-1:0] g;
        int j;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % NREQ;
            if (v[j]) begin
                g = '0;
                g[j] = 1'b1;
            end
        end
        return g;
    endfunction

    assign req_ready = reset ? '0 : rr_grant(req_valid, grant_ptr);
    assign acc = |req_ready;
    assign wb = acc && (a_sel != '0);
    assign nxt_ptr = (g_idx == 2'(NREQ - 1)) ? 2'd0 : g_idx + 2'd1;
    assign hazard = busy_mask[chk_selA] | busy_mask[chk_selB];

    always_comb begin
        g_idx = '0;
        a_sel = '0;
        a_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                g_idx = 2'(i);
                a_sel = req_sel[i*AW +: AW];
                a_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        busy_nxt = busy_mask;
        if (wb) busy_nxt[a_sel] = 1'b0;
        if (rsv_valid && rsv_sel != '0) busy_nxt[rsv_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busC <= '0;
            busCsel <= '0;
            en <= 1'b0;
            busy_mask <= '0;
            grant_ptr <= '0;
        end else begin
            en <= wb;
            if (wb) begin
                busC <= a_data;
                busCsel <= a_sel;
            end
            if (acc) grant_ptr <= nxt_ptr;
            busy_mask <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_reg_wb_sched.sv
// tb_reg_wb_sched: random and directed checks of reg_wb_sched against a behavioural model
module tb_reg_wb_sched;
    localparam int NREQ = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*AW-1:0] req_sel = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0] req_ready;
    logic [DW-1:0] busC;
    logic [AW-1:0] busCsel;
    logic en;
    logic rsv_valid = 1'b0;
    logic [AW-1:0] rsv_sel = '0;
    logic [AW-1:0] chk_selA = '0;
    logic [AW-1:0] chk_selB = '0;
    logic hazard;
    logic [2**AW-1:0] busy_mask;
    logic [1:0] grant_ptr;

    int total = 0;
    int bad = 0;
    logic started = 1'b0;

    reg_wb_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
        .req_data(req_data), .req_ready(req_ready), .busC(busC), .busCsel(busCsel),
        .en(en), .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .chk_selA(chk_selA),
        .chk_selB(chk_selB), .hazard(hazard), .busy_mask(busy_mask), .grant_ptr(grant_ptr)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: state as plain integers and a bit array
    logic [31:0] m_busy;
    int m_ptr;
    logic m_en;
    logic [DW-1:0] m_c;
    logic [AW-1:0] m_sel;
    int m_last_gnt;
    int mg;
    logic [AW-1:0] ms;
    logic [31:0] nb;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= '0;
            m_ptr <= 0;
            m_en <= 1'b0;
            m_c <= '0;
            m_sel <= '0;
            m_last_gnt <= -1;
        end else begin
            mg = pick(req_valid, m_ptr);
            nb = m_busy;
            m_last_gnt <= mg;
            m_en <= 1'b0;
            if (mg >= 0) begin
                ms = req_sel[mg*AW +: AW];
                m_ptr <= (mg + 1) % NREQ;
                if (ms != 0) begin
                    m_en <= 1'b1;
                    m_c <= req_data[mg*DW +: DW];
                    m_sel <= ms;
                    nb[ms] = 1'b0;
                end
            end
            if (rsv_valid && rsv_sel != 0) nb[rsv_sel] = 1'b1;
            m_busy <= nb;
        end
    end

    int cp;
    logic [NREQ-1:0] ce;

    always @(negedge clk) begin
        if (started) begin
            cp = pick(req_valid, m_ptr);
            ce = '0;
            if (!reset && cp >= 0) ce[cp] = 1'b1;
            chk("en", 64'(en), 64'(m_en));
            chk("busC", 64'(busC), 64'(m_c));
            chk("busCsel", 64'(busCsel), 64'(m_sel));
            chk("busy_mask", 64'(busy_mask), 64'(m_busy));
            chk("grant_ptr", 64'(grant_ptr), 64'(m_ptr));
            chk("req_ready", 64'(req_ready), 64'(ce));
            chk("hazard", 64'(hazard), 64'(m_busy[chk_selA] | m_busy[chk_selB]));
        end
    end

    initial begin
        reset = 1'b1;
        step();
        started = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_ptr", 64'(grant_ptr), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_hazard", 64'(hazard), 64'd0);

        req_valid = 3'b001;
        req_sel[0 +: AW] = 5'd5;
        req_data[0 +: DW] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        #1;
        chk("single_en", 64'(en), 64'd1);
        chk("single_sel", 64'(busCsel), 64'd5);
        chk("single_data", 64'(busC), 64'hDEADBEEF);
        step();
        #1;
        chk("single_en_drop", 64'(en), 64'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 3'b111;
        req_sel = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3333, 32'h2222, 32'h1111};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), 64'(1 << (k % 3)));
            step();
            #1;
            chk("rr_en", 64'(en), 64'd1);
            chk("rr_sel", 64'(busCsel), 64'(k % 3 + 1));
        end
        req_valid = '0;

        rsv_valid = 1'b1;
        rsv_sel = 5'd7;
        chk_selA = 5'd7;
        chk_selB = 5'd0;
        #1;
        chk("raw_pre", 64'(hazard), 64'd0);
        step();
        rsv_valid = 1'b0;
        #1;
        chk("raw_set", 64'(hazard), 64'd1);
        req_valid = 3'b001;
        req_sel[0 +: AW] = 5'd7;
        #1;
        chk("raw_hold", 64'(hazard), 64'd1);
        step();
        req_valid = '0;
        #1;
        chk("raw_clear", 64'(hazard), 64'd0);
        chk("raw_mask", 64'(busy_mask), 64'd0);

        rsv_valid = 1'b1;
        rsv_sel = 5'd9;
        step();
        req_valid = 3'b001;
        req_sel[0 +: AW] = 5'd9;
        step();
        #1;
        chk("setwins", 64'(busy_mask), 64'h200);
        rsv_sel = 5'd10;
        step();
        req_valid = '0;
        rsv_valid = 1'b0;
        #1;
        chk("set_clear_diff", 64'(busy_mask), 64'h400);

        req_valid = 3'b001;
        req_sel[0 +: AW] = 5'd0;
        #1;
        chk("r0_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        #1;
        chk("r0_en", 64'(en), 64'd0);
        chk("r0_busy", 64'(busy_mask), 64'h400);

        req_valid = 3'b010;
        req_sel[AW +: AW] = 5'd3;
        step();
        req_valid = '0;
        #1;
        chk("mid_en_pre", 64'(en), 64'd1);
        reset = 1'b1;
        step();
        #1;
        chk("mid_en", 64'(en), 64'd0);
        chk("mid_busy", 64'(busy_mask), 64'd0);
        chk("mid_ptr", 64'(grant_ptr), 64'd0);
        reset = 1'b0;
        step();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || m_last_gnt == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_sel[i*AW +: AW] = 5'($urandom_range(0, 11));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_sel = 5'($urandom_range(0, 11));
            chk_selA = 5'($urandom_range(0, 11));
            chk_selB = 5'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Write-back scheduler for the CPU register bank.
- Shares the bank's single write port (data, select, enable) among NREQ write-back requesters using round-robin arbitration.
- Keeps a 32-entry busy scoreboard of destination registers with outstanding writes, so issue logic can stall on read-after-write hazards.
- Sits between the execution/load units and the register bank.

Parameters:
NREQ, 3, number of write-back requesters (2..4)
DW, 32, data width of the register bank
AW, 5, register select width (2**AW registers; register 0 hard-wired to zero)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester write-back request
req_sel  input  NREQ*AW  per-requester destination register; requester i uses bits [i*AW +: AW]
req_data  input  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
req_ready  output  NREQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i]
busC  output  DW  write data to the register bank (registered)
busCsel  output  AW  write select to the register bank (registered)
en  output  1  write enable to the register bank (registered)
rsv_valid  input  1  issue logic reserves a destination register
rsv_sel  input  AW  register being reserved
chk_selA  input  AW  source A to check for hazard
chk_selB  input  AW  source B to check for hazard
hazard  output  1  chk_selA or chk_selB is busy (combinational)
busy_mask  output  2**AW  scoreboard state; bit 0 always 0
grant_ptr  output  2  current round-robin priority pointer (debug)

Behaviour:
- Reset: all flops update only on a clk edge where reset=1. Then busC=0, busCsel=0, en=0, busy_mask=0, grant_ptr=0. req_ready is all-zero while reset=1.
- Arbitration:
  - Combinational.
  - Search starts at index grant_ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - At most one ready bit is high per cycle.
  - No valid request gives req_ready=0.
- Pointer update: on an accepted request from index g, grant_ptr <= (g+1) mod NREQ. With no acceptance the pointer holds.
- Write port:
  - Latency is 1 cycle. A request accepted at edge N appears on busC/busCsel/en from edge N+1 for exactly one cycle.
  - en is high only in the cycle after an acceptance with sel != 0.
  - Otherwise en=0, and busC/busCsel hold their last values.
  - An accepted write to register 0 is consumed (ready=1) but produces en=0. It does not touch the scoreboard.
- Scoreboard update, evaluated each edge:
  - clear: an accepted request with sel != 0 clears busy[sel].
  - set: rsv_valid=1 with rsv_sel != 0 sets busy[rsv_sel].
  - Same register set and cleared in the same cycle: set wins (the newer producer is outstanding).
  - Different registers: both updates take effect.
  - Reserving an already-busy register keeps it busy (no counting).
  - Clearing a non-busy register is harmless.
- Hazard:
  - hazard = busy[chk_selA] | busy[chk_selB], from the registered busy_mask.
  - A clear at edge N drops hazard from N+1.
  - Selecting register 0 never raises hazard.
- Requesters must hold req_valid/req_sel/req_data stable until accepted; the block does not buffer unaccepted requests.
- Reset mid-operation: an in-flight en pulse is cancelled (en=0 the cycle after the reset edge). Pending reservations are discarded. Requesters must re-issue.
- grant_ptr values >= NREQ are unreachable.

Test Plan:
- Reset then idle: assert reset 2 cycles, no requests -> en=0, busy_mask=0, grant_ptr=0, req_ready=000, hazard=0.
- Single write: req_valid=001, req_sel[0]=5, req_data[0]=0xDEADBEEF -> req_ready=001 in the same cycle; next cycle en=1, busCsel=5, busC=0xDEADBEEF; following cycle en=0.
- Round-robin fairness: all three valid continuously (sels 1,2,3), held until accepted and then re-asserted -> grant order 0,1,2,0,1,2; en high every cycle; busCsel sequence 1,2,3,1,2,3.
- Scoreboard RAW:
  - rsv_valid with rsv_sel=7, then chk_selA=7 -> hazard=1 from the next cycle.
  - Write-back to 7 accepted at edge N -> hazard=0 from N+1.
  - chk_selB=0 -> hazard=0 throughout.
- Simultaneous set/clear: at the edge where the write to 9 is accepted, also rsv_sel=9 -> busy[9] stays 1. Same case with rsv_sel=10 -> busy[9]=0, busy[10]=1.
- Register 0 and mid-op reset:
  - Request with sel=0 -> accepted, en stays 0, busy_mask unchanged.
  - Reset asserted the edge after an acceptance -> en=0, busy_mask=0, grant_ptr=0.
